prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, instruction-memory address width; LEN and WADDR are ADDR_W bits wide.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: START  input  1  begin a load session; sampled only in IDLE or ERROR.
REQ-005 SHALL have port: LEN  input  ADDR_W  instruction count, captured on accepted START; 0 means 2^ADDR_W.
REQ-006 SHALL have port: DIN  input  8  instruction byte stream, MSB byte first.
REQ-007 SHALL have port: DIN_VALID  input  1  DIN holds a byte.
REQ-008 SHALL have port: DIN_READY  output  1  loader accepts DIN this cycle.
REQ-009 SHALL have port: WE  output  1  instruction-memory write strobe.
REQ-010 SHALL have port: WADDR  output  ADDR_W  write address.
REQ-011 SHALL have port: WDATA  output  21  assembled instruction {INSTYPE, I/R, OPCODE, TGT, AMUX, BMUX/IMM}.
REQ-012 SHALL have port: BOOT  output  1  high while loading; holds the CPU in boot and selects the manual address path.
REQ-013 SHALL have port: DONE  output  1  one-cycle pulse after the final write.
REQ-014 SHALL have port: ERR  output  1  sticky framing error.

Function
REQ-015 SHALL use states IDLE, B0, B1, B2, WRITE, ERROR.
REQ-016 Byte transfer SHALL occur only on a rising edge with DIN_VALID=1 and DIN_READY=1.
REQ-017 DIN_READY SHALL be 1 exactly in states B0, B1 and B2, and SHALL be combinational from state only, never from DIN_VALID.
REQ-018 IDLE: START=1 SHALL capture LEN into the remaining counter, clear WADDR to 0, and go to B0.
REQ-019 B0 transfer: DIN[7:5] nonzero SHALL go to ERROR; otherwise DIN[4:0] SHALL be stored to WDATA[20:16] and the FSM SHALL go to B1.
REQ-020 B1 transfer SHALL store DIN to WDATA[15:8] and go to B2.
REQ-021 B2 transfer SHALL store DIN to WDATA[7:0] and go to WRITE.
REQ-022 In B0, B1 and B2 without a transfer, the FSM SHALL hold state and stored bits; there is no timeout.
REQ-023 WRITE SHALL last exactly one cycle with WE=1, WADDR and WDATA stable; WE SHALL be 0 in every other state.
REQ-024 On leaving WRITE, WADDR SHALL increment modulo 2^ADDR_W and the remaining counter SHALL decrement.
REQ-025 On leaving WRITE with remaining count 1, the FSM SHALL go to IDLE with DONE=1 for that next cycle; otherwise it SHALL go to B0.
REQ-026 Minimum throughput SHALL be 4 cycles per instruction with DIN_VALID held high.
REQ-027 BOOT SHALL be 1 in B0, B1, B2 and WRITE, and 0 in IDLE and ERROR.
REQ-028 ERROR SHALL set ERR=1 and hold it; START=1 in ERROR SHALL clear ERR and restart as in REQ-018.
REQ-029 START SHALL be ignored in B0, B1, B2 and WRITE.
REQ-030 With LEN=0, the loader SHALL write 2^ADDR_W instructions; WADDR SHALL wrap to 0 at the end, after which DONE pulses.
REQ-031 ERR SHALL not be cleared by DONE.
REQ-032 WADDR SHALL retain its last value in IDLE.
REQ-033 WDATA SHALL retain its last assembled value in IDLE.

Reset
REQ-034 reset_n=0 SHALL, at any time including mid-session, immediately force IDLE, WE=0, DIN_READY=0, BOOT=0, DONE=0, ERR=0, WADDR=0, WDATA=0, and remaining counter=0.
REQ-035 A byte partly assembled before reset SHALL be discarded, and no write SHALL occur for it.
REQ-036 Reset release SHALL take effect on the first CLK edge after reset_n rises, with the FSM in IDLE.

Verification
REQ-037 Case 1: LEN=2, stream 0x0B,0x82,0x05,0x0D,0x00,0x07 with DIN_VALID held -> WE at WADDR 0 with WDATA=21'h0B8205, WE at WADDR 1 with WDATA=21'h0D0007, writes 4 cycles apart, then DONE pulse and BOOT=0.
REQ-038 Case 2: DIN_VALID toggling randomly -> same writes as Case 1; no byte lost or duplicated; DIN_READY never depends on DIN_VALID.
REQ-039 Case 3: first byte 0x2B -> ERROR, ERR=1, BOOT=0, no WE; then START with LEN=1 and bytes 0x00,0x00,0x01 -> ERR=0, write at WADDR 0 with WDATA=21'h000001.
REQ-040 Case 4: ADDR_W=8, LEN=0 -> 256 writes at WADDR 0..255, WADDR wraps to 0, then a single DONE pulse.
REQ-041 Case 5: reset_n low after byte B1 of instruction 3 -> all outputs at reset values asynchronously; no WE for the partial word; a fresh START reloads from WADDR 0.
REQ-042 Case 6: START pulsed during B1 -> ignored; LEN count and WADDR sequence unchanged.

Source files
------------

// File: rtl/prog_loader.sv
// Serial instruction loader: assembles three bytes (MSB first) into a 21-bit
// instruction and writes it to sequential instruction-memory addresses.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              START,
  input  logic [ADDR_W-1:0] LEN,
  input  logic [7:0]        DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [20:0]       WDATA,
  output logic              BOOT,
  output logic              DONE,
  output logic              ERR,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_B0    = 3'd1,
    S_B1    = 3'd2,
    S_B2    = 3'd3,
    S_WRITE = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] rem_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [20:0]       wdata_q;
  logic              done_q;
  logic              err_q;
  logic              xfer;

  // Handshake: a byte moves on a rising edge when DIN_VALID and DIN_READY are
  // both high; DIN_READY is decoded from state alone and never looks at DIN_VALID.
  assign DIN_READY   = (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2);
  assign xfer        = DIN_VALID && DIN_READY;
  assign WE          = (state_q == S_WRITE);
  assign BOOT        = DIN_READY || (state_q == S_WRITE);
  assign WADDR       = waddr_q;
  assign WDATA       = wdata_q;
  assign DONE        = done_q;
  assign ERR         = err_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (START) begin
            rem_q   <= LEN;
            waddr_q <= '0;
            err_q   <= 1'b0;
            state_q <= S_B0;
          end
        end
        S_B0: begin
          // Only 5 bits of the first byte are meaningful; anything above is a framing error.
          if (xfer) begin
            if (|DIN[7:5]) begin
              err_q   <= 1'b1;
              state_q <= S_ERROR;
            end else begin
              wdata_q[20:16] <= DIN[4:0];
              state_q        <= S_B1;
            end
          end
        end
        S_B1: begin
          if (xfer) begin
            wdata_q[15:8] <= DIN;
            state_q       <= S_B2;
          end
        end
        S_B2: begin
          if (xfer) begin
            wdata_q[7:0] <= DIN;
            state_q      <= S_WRITE;
          end
        end
        S_WRITE: begin
          // A count of 0 loaded from LEN wraps through the full address space.
          waddr_q <= waddr_q + ADDR_W'(1);
          rem_q   <= rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_B0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
